// File: rtl/riscv_core_dmem_responder.sv
// riscv_core_dmem_responder: fixed-latency block-read / strobed-write memory responder for the D-cache.
// Define DMEM_RESP_LFSR_JITTER_EN to add 0..3 cycles of LFSR-driven latency jitter per request.
module riscv_core_dmem_responder #(
    parameter int ADDR_WIDTH      = 64,
    parameter int CORE_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 256,
    parameter int MEM_DEPTH_WORDS = 4096,
    parameter int READ_LATENCY    = 4,
    parameter int WRITE_LATENCY   = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_mem_read_req,
    input  logic [ADDR_WIDTH-1:0]      i_mem_read_address,
    output logic [AXI_DATA_WIDTH-1:0]  o_mem_read_data,
    output logic                       o_mem_read_done,
    input  logic                       i_mem_write_valid,
    input  logic [CORE_DATA_WIDTH-1:0] i_mem_write_data,
    input  logic [ADDR_WIDTH-1:0]      i_mem_write_address,
    input  logic [7:0]                 i_mem_write_strobe,
    output logic                       o_mem_write_done,
    output logic                       o_addr_error
);
    localparam int IW = $clog2(MEM_DEPTH_WORDS);
    localparam int NW = AXI_DATA_WIDTH / CORE_DATA_WIDTH;
    localparam int CW = 16;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;

    state_t                     state, state_nxt;
    logic [CW-1:0]              cnt, cnt_nxt, jit;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [CORE_DATA_WIDTH-1:0] data_q, lane_data;
    logic [7:0]                 strb_q, lane_strb;
    logic [CORE_DATA_WIDTH-1:0] mem [MEM_DEPTH_WORDS];
    logic [IW-1:0]              idx;
    logic                       oor, commit, rd_commit, wr_commit;
    logic [AXI_DATA_WIDTH-1:0]  blk;

    assign idx       = addr_q[IW+2:3];
    assign oor       = |(addr_q >> (IW + 3));
    assign lane_data = data_q << {addr_q[2:0], 3'b000};
    assign lane_strb = strb_q << addr_q[2:0];
    assign rd_commit = commit && state == READ_WAIT;
    assign wr_commit = commit && state == WRITE_WAIT;

    for (genvar g = 0; g < NW; g++) begin : g_blk
        assign blk[g*CORE_DATA_WIDTH +: CORE_DATA_WIDTH] = mem[idx + IW'(g)];
    end

`ifdef DMEM_RESP_LFSR_JITTER_EN
    logic [7:0] lfsr;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) lfsr <= 8'hA5;
        else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign jit = CW'(lfsr[1:0]);
`else
    assign jit = '0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (i_mem_read_req) begin
                    state_nxt = READ_WAIT;
                    cnt_nxt   = CW'(READ_LATENCY - 1) + jit;
                end else if (i_mem_write_valid) begin
                    state_nxt = WRITE_WAIT;
                    cnt_nxt   = CW'(WRITE_LATENCY - 1) + jit;
                end
            end
            READ_WAIT, WRITE_WAIT: begin
                // A dropped request aborts silently; nothing is written or returned.
                if (!(state == READ_WAIT ? i_mem_read_req : i_mem_write_valid)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = DONE;
                    commit    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            o_mem_read_done  <= 1'b0;
            o_mem_write_done <= 1'b0;
            o_addr_error     <= 1'b0;
            o_mem_read_data  <= '0;
            addr_q           <= '0;
            data_q           <= '0;
            strb_q           <= '0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            o_mem_read_done  <= rd_commit;
            o_mem_write_done <= wr_commit;
            o_addr_error     <= commit && oor;
            if (rd_commit) o_mem_read_data <= oor ? '0 : blk;
            if (state == IDLE) begin
                addr_q <= i_mem_read_req ? (i_mem_read_address & ~ADDR_WIDTH'(31)) : i_mem_write_address;
                data_q <= i_mem_write_data;
                strb_q <= i_mem_write_strobe;
            end
        end
    end

    // Backing store is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge i_clk) begin
        if (wr_commit && !oor)
            for (int b = 0; b < 8; b++)
                if (lane_strb[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
    end
endmodule

// File: tb/tb_riscv_core_dmem_responder.sv
// tb_riscv_core_dmem_responder: directed scoreboard bench for riscv_core_dmem_responder.
module tb_riscv_core_dmem_responder;
    localparam int RL = 4;
    localparam int WL = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         rd_req, rd_done, wr_valid, wr_done, addr_err;
    logic [63:0]  rd_addr, wr_addr, wr_data;
    logic [7:0]   wr_strb;
    logic [255:0] rd_data;

    int           total = 0;
    int           bad = 0;
    int           n;
    logic         seen;
    logic [256:0] e;
    logic [63:0]  mm [int];
    logic [256:0] sbq [$];

    riscv_core_dmem_responder dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .i_mem_read_req      (rd_req),
        .i_mem_read_address  (rd_addr),
        .o_mem_read_data     (rd_data),
        .o_mem_read_done     (rd_done),
        .i_mem_write_valid   (wr_valid),
        .i_mem_write_data    (wr_data),
        .i_mem_write_address (wr_addr),
        .i_mem_write_strobe  (wr_strb),
        .o_mem_write_done    (wr_done),
        .o_addr_error        (addr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        logic [63:0] w;
        int off;
        if (a[63:15] != 0) return;
        off = int'(a[2:0]);
        w = mm.exists(int'(a[14:3])) ? mm[int'(a[14:3])] : 64'h0;
        for (int b = 0; b < 8; b++)
            if (b >= off && s[b - off]) w[8*b +: 8] = d[8*(b - off) +: 8];
        mm[int'(a[14:3])] = w;
    endfunction

    function automatic logic [256:0] model_block(input logic [63:0] a);
        logic [255:0] blk;
        int base;
        if (a[63:15] != 0) return {1'b1, 256'h0};
        base = int'(a[14:5]) * 4;
        for (int k = 0; k < 4; k++) blk[64*k +: 64] = mm[base + k];
        return {1'b0, blk};
    endfunction

    task automatic do_read(input logic [63:0] a, input string tag);
        logic [256:0] x;
        int c = 0;
        sbq.push_back(model_block(a));
        rd_req = 1'b1;
        rd_addr = a;
        do begin step(); c++; end while (!rd_done && c < 50);
        x = sbq.pop_front();
        chk({tag, "_done"}, rd_done, 1);
        chk({tag, "_lat"}, c - 1, RL);
        chk({tag, "_data"}, rd_data, x[255:0]);
        chk({tag, "_err"}, addr_err, x[256]);
        rd_req = 1'b0;
        step();
        chk({tag, "_pulse"}, rd_done, 0);
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic err, input string tag);
        int c = 0;
        wr_valid = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_strb = s;
        do begin step(); c++; end while (!wr_done && c < 50);
        model_write(a, d, s);
        chk({tag, "_done"}, wr_done, 1);
        chk({tag, "_lat"}, c - 1, WL);
        chk({tag, "_err"}, addr_err, err);
        wr_valid = 1'b0;
        step();
        chk({tag, "_pulse"}, wr_done, 0);
    endtask

    initial begin
        rd_req = 0; rd_addr = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; wr_strb = 0;
        #1 rst_n = 1'b0;
        #11;
        chk("rst_rd_done", rd_done, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_err", addr_err, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        step();

        // Preload words 0..3, 8..11 and 0x20..0x23 with full-strobe writes.
        for (int i = 0; i < 4; i++) do_write(64'h0 + 64'(8*i), {$urandom, $urandom}, 8'hFF, 1'b0, "pre0");
        for (int i = 0; i < 4; i++) do_write(64'h40 + 64'(8*i), 64'h1111_1111_1111_1111 * (i + 1), 8'hFF, 1'b0, "pre40");
        for (int i = 0; i < 4; i++) do_write(64'h100 + 64'(8*i), {$urandom, $urandom}, 8'hFF, 1'b0, "pre100");

        do_read(64'h40, "rd40");
        chk("rd40_const", rd_data, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

        do_write(64'h105, 64'hAB, 8'h01, 1'b0, "wr105");
        do_read(64'h100, "rd100");
        chk("rd100_byte5", rd_data[47:40], 8'hAB);
        do_write(64'h10E, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, 1'b0, "wr10e_trunc");
        do_read(64'h118, "rd118");

        // Read dropped two cycles after acceptance must not complete.
        rd_req = 1'b1; rd_addr = 64'h40;
        step(); step(); step();
        rd_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); seen |= rd_done | wr_done; end
        chk("abort_nodone", seen, 0);
        do_write(64'h48, 64'h0123_4567_89AB_CDEF, 8'h3C, 1'b0, "wr_after_abort");
        do_read(64'h40, "rd_after_abort");

        do_read(64'h1_0000, "rd_oor");
        do_write(64'h1_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, "wr_oor");
        do_read(64'h0, "rd0_untouched");

        // Reset during READ_WAIT clears outputs immediately and keeps memory.
        rd_req = 1'b1; rd_addr = 64'h100;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_rd_done", rd_done, 0);
        rd_req = 1'b0;
        step();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin step(); seen |= rd_done; end
        chk("midrst_nodone", seen, 0);
        do_read(64'h100, "rd_after_rst");

        // Simultaneous read and write: read first, write one idle cycle after read DONE.
        sbq.push_back(model_block(64'h40));
        rd_req = 1'b1; rd_addr = 64'h40;
        wr_valid = 1'b1; wr_addr = 64'h4A; wr_data = 64'h5A5A_5A5A_5A5A_5A5A; wr_strb = 8'h0F;
        n = 0;
        do begin step(); n++; end while (!rd_done && n < 50);
        e = sbq.pop_front();
        chk("both_rd_lat", n - 1, RL);
        chk("both_rd_data", rd_data, e[255:0]);
        rd_req = 1'b0;
        n = 0;
        do begin step(); n++; end while (!wr_done && n < 50);
        chk("both_wr_lat", n, WL + 2);
        model_write(64'h4A, 64'h5A5A_5A5A_5A5A_5A5A, 8'h0F);
        wr_valid = 1'b0;
        step();
        do_read(64'h40, "both_readback");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/riscv_core_dmem_responder.md
Name: riscv_core_dmem_responder

Overview:
- Memory-side responder for the data-cache miss/write-through handshake.
- Accepts block-read requests (i_mem_read_req/i_mem_read_address) and single-word strobed writes (i_mem_write_valid/data/address/strobe) from the D-cache controller.
- Answers each with a one-cycle done pulse after a fixed latency, from an internal word-addressed backing store.
- Serves as the on-chip data scratchpad and as the bench memory for cache bring-up.

Parameters:
- ADDR_WIDTH, 64, address width
- CORE_DATA_WIDTH, 64, write word width; one 64-bit memory word
- AXI_DATA_WIDTH, 256, read block width (4 words)
- MEM_DEPTH_WORDS, 4096, backing store depth in 64-bit words; power of two
- READ_LATENCY, 4, cycles from read acceptance to o_mem_read_done; >=1
- WRITE_LATENCY, 2, cycles from write acceptance to o_mem_write_done; >=1

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_mem_read_req  in  1  block read request; level, held until done
- i_mem_read_address  in  ADDR_WIDTH  block address
- o_mem_read_data  out  AXI_DATA_WIDTH  returned block
- o_mem_read_done  out  1  one-cycle read completion pulse
- i_mem_write_valid  in  1  write request; level, held until done
- i_mem_write_data  in  CORE_DATA_WIDTH  store data, LSB-aligned
- i_mem_write_address  in  ADDR_WIDTH  byte address of store
- i_mem_write_strobe  in  8  LSB-aligned byte enables
- o_mem_write_done  out  1  one-cycle write completion pulse
- o_addr_error  out  1  pulses with done when the word index is out of range

Behaviour:
- Reset (async, active-low):
  - FSM goes to IDLE.
  - Latency counter is 0.
  - o_mem_read_done, o_mem_write_done and o_addr_error are 0.
  - o_mem_read_data is 0.
  - Backing store is not cleared.
- Reset mid-transaction aborts the transaction: no done pulse and no memory update.
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, DONE. All outputs are registered.
- IDLE:
  - i_mem_read_req=1: capture block base = address with bits [4:0] forced to 0. Counter loads READ_LATENCY-1. Go to READ_WAIT.
  - else i_mem_write_valid=1: capture address, data and strobe. Counter loads WRITE_LATENCY-1. Go to WRITE_WAIT.
  - Read wins when both are high.
- READ_WAIT / WRITE_WAIT:
  - Counter decrements each cycle while nonzero.
  - If the request line drops before completion: abort, go to IDLE, no done pulse, no write.
  - When counter==0 and the request is still high, at that edge:
    - Read: o_mem_read_data is loaded with words [base_idx+k] in bits [64k+63:64k], k=0..3. o_mem_read_done is set to 1.
    - Write: the memory word is updated. o_mem_write_done is set to 1.
    - Go to DONE.
  - Resulting latency: with READ_LATENCY=1, done is high in the cycle after acceptance. In general, done is high exactly N cycles after the accepting edge.
- DONE:
  - Done pulses clear after one cycle.
  - New requests are not sampled here. The requester drops its request on the done cycle.
  - Go to IDLE. Back-to-back spacing: one idle cycle between done and the next acceptance.
- o_mem_read_data holds its value until the next read completion.
- Word index = address[log2(MEM_DEPTH_WORDS)+2:3]. Index is out of range if any address bit above that field is nonzero. Out-of-range behaviour:
  - Read returns all-zero data.
  - Write is discarded.
  - Done is still pulsed, with o_addr_error=1 in the same cycle.
- Write alignment:
  - off = address[2:0].
  - Lane data = i_mem_write_data << 8*off.
  - Lane strobe = (i_mem_write_strobe << off) truncated to 8 bits.
  - Only strobed bytes of the target word change.
- A read of the same word on the cycle after a write's DONE returns the new data.

Optional Feature:
- Macro DMEM_RESP_LFSR_JITTER_EN.
- When defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 at reset) advances every cycle.
  - At acceptance, lfsr[1:0] is added to the loaded latency (0..3 extra cycles).
  - The LFSR value at each acceptance is exposed only internally.
- When undefined: latency is exactly READ_LATENCY / WRITE_LATENCY, and no LFSR logic exists.

Test Plan:
- Read at 0x0000_0040 after preloading words 8..11 = 0x11..,0x22..,0x33..,0x44.. -> done exactly 4 cycles after acceptance; data = {0x44..,0x33..,0x22..,0x11..}; done high for one cycle.
- Write 0xAB, strobe 8'h01, address 0x105, then read block 0x100 -> word 0x20 byte 5 = 0xAB; other bytes unchanged; write done 2 cycles after acceptance.
- Read req dropped 2 cycles after acceptance -> no done; FSM back in IDLE; next write accepted normally.
- Address 0x0001_0000 (index out of range for 4096 words) -> read data 0 with done and o_addr_error=1; write with done and o_addr_error=1 leaves memory untouched.
- Reset asserted during READ_WAIT -> outputs 0 immediately; no done after release; memory contents retained.
- Read and write requested in the same IDLE cycle -> read is serviced first; write is accepted one cycle after the read's DONE.
